// File: rtl/game_ctrl.sv
// Two-player round-based game controller: start handshake, timed scoring window,
// result comparison against a rival score, and multi-round match sequencing.
module game_ctrl #(
  parameter  int SCORE_W     = 8,
  parameter  int GAME_CYCLES = 1000,
  parameter  int ROUNDS      = 3,
  localparam int TW          = $clog2(GAME_CYCLES + 1),
  localparam int RW          = $clog2(ROUNDS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_start,
  input  logic               btn_ack,
  input  logic               start_sig,
  input  logic               hit,
  input  logic [SCORE_W-1:0] rival_score,
  input  logic               rival_valid,
  output logic [SCORE_W-1:0] my_score,
  output logic [1:0]         state_out,
  output logic [TW-1:0]      time_left,
  output logic [RW-1:0]      round_num,
  output logic               led_win,
  output logic               led_lose,
  output logic               led_draw,
  output logic               match_over
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WAIT  = 2'b01,
    ST_GAME  = 2'b10,
    ST_SCORE = 2'b11
  } state_t;

  localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};
  localparam logic [TW-1:0]      TIME_LOAD  = TW'(GAME_CYCLES);
  localparam logic [RW-1:0]      ROUND_LAST = RW'(ROUNDS);

  state_t             state_q,      state_d;
  logic [SCORE_W-1:0] my_score_q,   my_score_d;
  logic [SCORE_W-1:0] rival_q,      rival_d;
  logic [TW-1:0]      time_left_q,  time_left_d;
  logic [RW-1:0]      round_q,      round_d;
  logic               led_win_q,    led_win_d;
  logic               led_lose_q,   led_lose_d;
  logic               led_draw_q,   led_draw_d;
  logic               match_over_q, match_over_d;
  logic               res_valid_q,  res_valid_d;
  logic               btn_start_d_q;
  logic               btn_ack_d_q;

  logic start_edge_s;
  logic ack_edge_s;

  // Rising-edge detection against last cycle's button level.
  always_comb begin
    start_edge_s = btn_start & ~btn_start_d_q;
    ack_edge_s   = btn_ack & ~btn_ack_d_q;
  end

  // Next-state and datapath update for every state.
  always_comb begin
    state_d      = state_q;
    my_score_d   = my_score_q;
    rival_d      = rival_q;
    time_left_d  = time_left_q;
    round_d      = round_q;
    led_win_d    = led_win_q;
    led_lose_d   = led_lose_q;
    led_draw_d   = led_draw_q;
    match_over_d = 1'b0;
    res_valid_d  = res_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (start_edge_s) begin
          state_d = ST_WAIT;
          round_d = RW'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WAIT: begin
        if (start_sig) begin
          state_d     = ST_GAME;
          time_left_d = TIME_LOAD;
          my_score_d  = '0;
          led_win_d   = 1'b0;
          led_lose_d  = 1'b0;
          led_draw_d  = 1'b0;
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_GAME: begin
        if (hit && (my_score_q != SCORE_MAX)) begin
          my_score_d = my_score_q + SCORE_W'(1);
        end else begin
          my_score_d = my_score_q;
        end
        // A zero count can only follow corruption; leave GAME rather than wrap.
        if (time_left_q <= TW'(1)) begin
          state_d     = ST_SCORE;
          time_left_d = '0;
        end else begin
          time_left_d = time_left_q - TW'(1);
        end
      end

      ST_SCORE: begin
        if (res_valid_q) begin
          led_win_d  = (my_score_q > rival_q);
          led_lose_d = (my_score_q < rival_q);
          led_draw_d = (my_score_q == rival_q);
        end else begin
          led_win_d  = led_win_q;
        end
        if (!res_valid_q && rival_valid) begin
          rival_d     = rival_score;
          res_valid_d = 1'b1;
        end else if (res_valid_q && ack_edge_s) begin
          res_valid_d = 1'b0;
          if (round_q < ROUND_LAST) begin
            state_d = ST_WAIT;
            round_d = round_q + RW'(1);
          end else begin
            state_d      = ST_IDLE;
            round_d      = '0;
            match_over_d = 1'b1;
          end
        end else begin
          res_valid_d = res_valid_q;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        round_d     = '0;
        res_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      my_score_q    <= '0;
      rival_q       <= '0;
      time_left_q   <= '0;
      round_q       <= '0;
      led_win_q     <= 1'b0;
      led_lose_q    <= 1'b0;
      led_draw_q    <= 1'b0;
      match_over_q  <= 1'b0;
      res_valid_q   <= 1'b0;
      btn_start_d_q <= 1'b0;
      btn_ack_d_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      my_score_q    <= my_score_d;
      rival_q       <= rival_d;
      time_left_q   <= time_left_d;
      round_q       <= round_d;
      led_win_q     <= led_win_d;
      led_lose_q    <= led_lose_d;
      led_draw_q    <= led_draw_d;
      match_over_q  <= match_over_d;
      res_valid_q   <= res_valid_d;
      btn_start_d_q <= btn_start;
      btn_ack_d_q   <= btn_ack;
    end
  end

  assign my_score   = my_score_q;
  assign state_out  = state_q;
  assign time_left  = time_left_q;
  assign round_num  = round_q;
  assign led_win    = led_win_q;
  assign led_lose   = led_lose_q;
  assign led_draw   = led_draw_q;
  assign match_over = match_over_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: a 10-cycle/3-round instance for sequencing and
// a 4-bit-score instance for saturation and mid-GAME reset.
module tb_game_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       btn_start = 1'b0, btn_ack = 1'b0, start_sig = 1'b0, hit = 1'b0;
  logic [7:0] rival_score = 8'd0;
  logic       rival_valid = 1'b0;
  logic [7:0] my_score;
  logic [1:0] state_out;
  logic [3:0] time_left;
  logic [1:0] round_num;
  logic       led_win, led_lose, led_draw, match_over;

  logic       s_btn_start = 1'b0, s_start_sig = 1'b0, s_hit = 1'b0;
  logic [3:0] s_my_score;
  logic [1:0] s_state_out;
  logic [4:0] s_time_left;
  logic [0:0] s_round_num;
  logic       s_led_win, s_led_lose, s_led_draw, s_match_over;

  int checks = 0;
  int failures = 0;

  game_ctrl #(.SCORE_W(8), .GAME_CYCLES(10), .ROUNDS(3)) u_dut (
    .clk(clk), .rst(rst), .btn_start(btn_start), .btn_ack(btn_ack),
    .start_sig(start_sig), .hit(hit), .rival_score(rival_score),
    .rival_valid(rival_valid), .my_score(my_score), .state_out(state_out),
    .time_left(time_left), .round_num(round_num), .led_win(led_win),
    .led_lose(led_lose), .led_draw(led_draw), .match_over(match_over)
  );

  game_ctrl #(.SCORE_W(4), .GAME_CYCLES(30), .ROUNDS(1)) u_sat (
    .clk(clk), .rst(rst), .btn_start(s_btn_start), .btn_ack(1'b0),
    .start_sig(s_start_sig), .hit(s_hit), .rival_score(4'd0),
    .rival_valid(1'b0), .my_score(s_my_score), .state_out(s_state_out),
    .time_left(s_time_left), .round_num(s_round_num), .led_win(s_led_win),
    .led_lose(s_led_lose), .led_draw(s_led_draw), .match_over(s_match_over)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({state_out, my_score, time_left, round_num} !== 16'd0) begin
      failures++;
      $display("FAIL reset_regs: got st=%0d sc=%0d tl=%0d rn=%0d expected all 0",
               state_out, my_score, time_left, round_num);
    end
    checks++;
    if ({led_win, led_lose, led_draw, match_over} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_leds: got %b expected 0000", {led_win, led_lose, led_draw, match_over});
    end
    rst = 1'b0;
    tick();
    checks++;
    if (state_out !== 2'b00) begin
      failures++;
      $display("FAIL idle_after_reset: got %0d expected 0", state_out);
    end
  endtask

  task automatic test_start_held();
    btn_start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (state_out !== 2'b01 || round_num !== 2'd1) begin
        failures++;
        $display("FAIL start_held[%0d]: got st=%0d rn=%0d expected st=1 rn=1", i, state_out, round_num);
      end
    end
    btn_start = 1'b0;
    tick();
  endtask

  task automatic test_game();
    int exp_tl;
    start_sig = 1'b1;
    tick();
    start_sig = 1'b0;
    checks++;
    if (state_out !== 2'b10 || time_left !== 4'd10 || my_score !== 8'd0) begin
      failures++;
      $display("FAIL game_entry: got st=%0d tl=%0d sc=%0d expected st=2 tl=10 sc=0",
               state_out, time_left, my_score);
    end
    for (int i = 0; i < 10; i++) begin
      exp_tl = 10 - i;
      checks++;
      if (state_out !== 2'b10 || time_left !== 4'(exp_tl)) begin
        failures++;
        $display("FAIL game_count[%0d]: got st=%0d tl=%0d expected st=2 tl=%0d",
                 i, state_out, time_left, exp_tl);
      end
      hit = (exp_tl == 10 || exp_tl == 5 || exp_tl == 1);
      tick();
    end
    hit = 1'b0;
    checks++;
    if (state_out !== 2'b11 || time_left !== 4'd0 || my_score !== 8'd3) begin
      failures++;
      $display("FAIL game_done: got st=%0d tl=%0d sc=%0d expected st=3 tl=0 sc=3",
               state_out, time_left, my_score);
    end
    hit = 1'b1;
    tick();
    hit = 1'b0;
    checks++;
    if (my_score !== 8'd3) begin
      failures++;
      $display("FAIL hit_in_score: got %0d expected 3", my_score);
    end
  endtask

  task automatic test_result();
    rival_valid = 1'b1;
    rival_score = 8'd2;
    btn_ack     = 1'b1;
    tick();
    checks++;
    if (state_out !== 2'b11) begin
      failures++;
      $display("FAIL ack_coincident: got st=%0d expected 3", state_out);
    end
    rival_score = 8'd9;
    tick();
    rival_valid = 1'b0;
    btn_ack     = 1'b0;
    checks++;
    if ({led_win, led_lose, led_draw} !== 3'b100 || state_out !== 2'b11) begin
      failures++;
      $display("FAIL result_win: got leds=%b st=%0d expected leds=100 st=3",
               {led_win, led_lose, led_draw}, state_out);
    end
    tick();
    checks++;
    if ({led_win, led_lose, led_draw} !== 3'b100) begin
      failures++;
      $display("FAIL second_rival_ignored: got leds=%b expected 100", {led_win, led_lose, led_draw});
    end
    btn_ack = 1'b1;
    tick();
    btn_ack = 1'b0;
    checks++;
    if (state_out !== 2'b01 || round_num !== 2'd2 || led_win !== 1'b1 || match_over !== 1'b0) begin
      failures++;
      $display("FAIL ack_to_wait: got st=%0d rn=%0d win=%0d mo=%0d expected st=1 rn=2 win=1 mo=0",
               state_out, round_num, led_win, match_over);
    end
    tick();
  endtask

  task automatic play_round(input int nhits, input logic [7:0] rival, input logic [2:0] exp_leds,
                            input logic [1:0] exp_round);
    start_sig = 1'b1;
    tick();
    start_sig = 1'b0;
    checks++;
    if (state_out !== 2'b10 || {led_win, led_lose, led_draw} !== 3'b000 || round_num !== exp_round) begin
      failures++;
      $display("FAIL round%0d_entry: got st=%0d leds=%b rn=%0d expected st=2 leds=000 rn=%0d",
               exp_round, state_out, {led_win, led_lose, led_draw}, round_num, exp_round);
    end
    for (int i = 0; i < 10; i++) begin
      hit = (i < nhits);
      tick();
    end
    hit = 1'b0;
    checks++;
    if (state_out !== 2'b11 || my_score !== 8'(nhits)) begin
      failures++;
      $display("FAIL round%0d_score: got st=%0d sc=%0d expected st=3 sc=%0d",
               exp_round, state_out, my_score, nhits);
    end
    rival_valid = 1'b1;
    rival_score = rival;
    tick();
    rival_valid = 1'b0;
    tick();
    checks++;
    if ({led_win, led_lose, led_draw} !== exp_leds) begin
      failures++;
      $display("FAIL round%0d_leds: got %b expected %b", exp_round, {led_win, led_lose, led_draw}, exp_leds);
    end
    btn_ack = 1'b1;
    tick();
    btn_ack = 1'b0;
  endtask

  task automatic test_match();
    play_round(0, 8'd0, 3'b001, 2'd2);
    checks++;
    if (state_out !== 2'b01 || round_num !== 2'd3 || match_over !== 1'b0) begin
      failures++;
      $display("FAIL round2_ack: got st=%0d rn=%0d mo=%0d expected st=1 rn=3 mo=0",
               state_out, round_num, match_over);
    end
    play_round(4, 8'd200, 3'b010, 2'd3);
    checks++;
    if (state_out !== 2'b00 || round_num !== 2'd0 || match_over !== 1'b1) begin
      failures++;
      $display("FAIL match_end: got st=%0d rn=%0d mo=%0d expected st=0 rn=0 mo=1",
               state_out, round_num, match_over);
    end
    tick();
    checks++;
    if (match_over !== 1'b0 || state_out !== 2'b00) begin
      failures++;
      $display("FAIL match_pulse: got mo=%0d st=%0d expected mo=0 st=0", match_over, state_out);
    end
    checks++;
    if ({led_win, led_lose, led_draw} !== 3'b010 || my_score !== 8'd4) begin
      failures++;
      $display("FAIL idle_hold: got leds=%b sc=%0d expected leds=010 sc=4",
               {led_win, led_lose, led_draw}, my_score);
    end
  endtask

  task automatic test_saturate_reset();
    s_btn_start = 1'b1;
    tick();
    s_btn_start = 1'b0;
    s_start_sig = 1'b1;
    tick();
    s_start_sig = 1'b0;
    s_hit = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
    end
    s_hit = 1'b0;
    checks++;
    if (s_my_score !== 4'd15 || s_state_out !== 2'b10 || s_time_left !== 5'd10) begin
      failures++;
      $display("FAIL saturate: got sc=%0d st=%0d tl=%0d expected sc=15 st=2 tl=10",
               s_my_score, s_state_out, s_time_left);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({s_state_out, s_my_score, s_time_left, s_round_num} !== 12'd0 ||
        {s_led_win, s_led_lose, s_led_draw, s_match_over} !== 4'b0000) begin
      failures++;
      $display("FAIL mid_game_reset: got st=%0d sc=%0d tl=%0d rn=%0d expected all 0",
               s_state_out, s_my_score, s_time_left, s_round_num);
    end
    tick();
    checks++;
    if (s_state_out !== 2'b00 || state_out !== 2'b00) begin
      failures++;
      $display("FAIL post_reset_idle: got sat=%0d dut=%0d expected 0", s_state_out, state_out);
    end
  endtask

  initial begin
    test_reset();
    test_start_held();
    test_game();
    test_result();
    test_match();
    test_saturate_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter SCORE_W, default 8, bit width of my_score and rival_score.
REQ-002 Parameter GAME_CYCLES, default 1000, length of one GAME round in clock cycles (>=2).
REQ-003 Parameter ROUNDS, default 3, number of rounds per match (>=1).
REQ-004 Derived widths SHALL be TW = clog2(GAME_CYCLES+1) and RW = clog2(ROUNDS+1).
REQ-005 clk  in  1  single system clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 btn_start  in  1  level button; its rising edge starts a match.
REQ-008 btn_ack  in  1  level button; its rising edge acknowledges a round result.
REQ-009 start_sig  in  1  level start indicator from the second device.
REQ-010 hit  in  1  one-cycle scoring pulse.
REQ-011 rival_score  in  SCORE_W  rival round score; sampled only when rival_valid=1.
REQ-012 rival_valid  in  1  rival_score qualifier.
REQ-013 my_score  out  SCORE_W  local round score, registered.
REQ-014 state_out  out  2  current state encoding.
REQ-015 time_left  out  TW  remaining GAME cycles.
REQ-016 round_num  out  RW  current round, 1..ROUNDS; 0 when idle.
REQ-017 led_win, led_lose, led_draw  out  1 each  round result, registered, at most one high.
REQ-018 match_over  out  1  one-cycle pulse when the final round is acknowledged.

Function
REQ-019 States SHALL be IDLE=2'b00, WAIT=2'b01, GAME=2'b10, SCORE=2'b11; state_out SHALL equal the state register.
REQ-020 Button edges SHALL be detected as btn & ~btn_d, where btn_d is the value registered the previous cycle; a held button SHALL produce one edge only.
REQ-021 IDLE->WAIT on btn_start edge; the same clock edge SHALL set round_num=1. Any start_sig value in that cycle SHALL be ignored.
REQ-022 WAIT->GAME when start_sig=1; the same clock edge SHALL load time_left=GAME_CYCLES, clear my_score, and clear all three LEDs.
REQ-023 In GAME, time_left SHALL decrement by 1 per cycle; when time_left==1, the next state SHALL be SCORE and time_left SHALL become 0.
REQ-024 In GAME, hit=1 SHALL increment my_score by 1, saturating at 2^SCORE_W-1. A hit in the cycle with time_left==1 SHALL count.
REQ-025 hit SHALL be ignored outside GAME.
REQ-026 In SCORE, the first cycle with rival_valid=1 SHALL latch rival_score, set a result-valid flag, and on the next edge assert exactly one LED:
  - led_win if my_score > rival_score;
  - led_lose if my_score < rival_score;
  - led_draw if equal.
  Comparison is unsigned. Later rival_valid pulses in the same SCORE visit SHALL be ignored.
REQ-027 btn_ack edges in SCORE SHALL be ignored while result-valid=0, including an edge coincident with the first rival_valid.
REQ-028 btn_ack edge in SCORE with result-valid=1 and round_num<ROUNDS SHALL cause SCORE->WAIT and round_num+1.
REQ-029 btn_ack edge in SCORE with result-valid=1 and round_num==ROUNDS SHALL cause SCORE->IDLE, round_num=0, and match_over=1 for exactly one cycle.
REQ-030 LEDs and my_score SHALL hold their values through WAIT and IDLE until the next GAME entry clears them.
REQ-031 Leaving SCORE SHALL clear result-valid.

Reset
REQ-032 While rst=1 at a clock edge, the block SHALL set:
  - state=IDLE;
  - my_score, time_left, round_num = 0;
  - all LEDs, match_over, result-valid, and button-delay registers = 0.
REQ-033 Reset SHALL take priority over every transition, including mid-GAME and mid-SCORE; the first cycle after reset release SHALL behave as IDLE.

Verification
REQ-034 Reset then btn_start held 5 cycles -> exactly one IDLE->WAIT transition, round_num=1.
REQ-035 GAME_CYCLES=10, start_sig=1, 3 hits including one with time_left=1 -> SCORE after 10 GAME cycles, my_score=3, time_left=0.
REQ-036 my_score=3, rival_valid with rival_score=2, then a second rival_valid with rival_score=9 -> led_win=1 only; the second sample is ignored.
REQ-037 btn_ack edge coincident with the first rival_valid -> stays in SCORE; a later btn_ack edge -> WAIT with round_num=2.
REQ-038 ROUNDS=3, three complete rounds -> match_over high exactly one cycle, state=IDLE, round_num=0.
REQ-039 SCORE_W=4, 20 hits -> my_score=15 (saturated); rst asserted mid-GAME -> all outputs 0, state_out=2'b00 next cycle.
